// File: rtl/binary_quiz_controller.sv
// Round-based binary add/sub quiz sequencer for the arcade game mux.
// Optional feature: define STREAK_BONUS_EN for the consecutive-correct score bonus.
module binary_quiz_controller #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned ROUND_SECS = 10,
  parameter int unsigned NUM_ROUNDS = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn_pulse,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [63:0] grid,
  output logic        check_ok,
  output logic [7:0]  score
);

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]    SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]    LFSR_TAPS = 8'hB8;  // x^8+x^6+x^5+x^4+1, right-shifting Galois form

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ASK, S_JUDGE, S_RESULT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic          op_q, op_d;
  logic [3:0]    secs_q, secs_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [4:0]    ans_q, ans_d;
  logic          timeout_q, timeout_d;
  logic          ok_q, ok_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    round_q, round_d;
`ifdef STREAK_BONUS_EN
  logic [1:0]    streak_q, streak_d;
`endif

  logic [15:0]   led_q, led_d;
  logic [63:0]   grid_q, grid_d;
  logic          check_ok_q;
  logic [7:0]    score_out_q;

  logic [4:0]    expected;
  logic          correct;
  logic [1:0]    score_inc;
  logic [8:0]    score_sum;
  logic [7:0]    therm;
  logic          unused_inputs;

  assign unused_inputs = ^{sw[15:9], sw[7:5], btn_pulse[3:1]};

  assign expected = op_q ? {(a_q < b_q), 4'(a_q - b_q)}
                         : ({1'b0, a_q} + {1'b0, b_q});
  assign correct  = !timeout_q && (ans_q == expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      secs_q      <= '0;
      tick_q      <= '0;
      ans_q       <= '0;
      timeout_q   <= 1'b0;
      ok_q        <= 1'b0;
      score_q     <= '0;
      round_q     <= '0;
`ifdef STREAK_BONUS_EN
      streak_q    <= '0;
`endif
      led_q       <= '0;
      grid_q      <= '0;
      check_ok_q  <= 1'b0;
      score_out_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      secs_q      <= secs_d;
      tick_q      <= tick_d;
      ans_q       <= ans_d;
      timeout_q   <= timeout_d;
      ok_q        <= ok_d;
      score_q     <= score_d;
      round_q     <= round_d;
`ifdef STREAK_BONUS_EN
      streak_q    <= streak_d;
`endif
      led_q       <= led_d;
      grid_q      <= grid_d;
      check_ok_q  <= ok_q;
      score_out_q <= score_q;
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    secs_d    = secs_q;
    tick_d    = tick_q;
    ans_d     = ans_q;
    timeout_d = timeout_q;
    ok_d      = ok_q;
    score_d   = score_q;
    round_d   = round_q;
`ifdef STREAK_BONUS_EN
    streak_d  = streak_q;
    score_inc = (streak_q >= 2'd2) ? 2'd2 : 2'd1;
`else
    score_inc = 2'd1;
`endif
    score_sum = {1'b0, score_q} + {7'd0, score_inc};

    if (btn_pulse[4] && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ok_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (btn_pulse[0]) begin
          score_d  = '0;
          round_d  = '0;
`ifdef STREAK_BONUS_EN
          streak_d = '0;
`endif
          state_d  = S_LOAD;
        end
        S_LOAD: begin
          a_d       = lfsr_q[3:0];
          b_d       = lfsr_q[7:4];
          op_d      = sw[8];
          lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
          secs_d    = 4'(ROUND_SECS);
          tick_d    = '0;
          ok_d      = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_ASK;
        end
        S_ASK: begin
          // A submit on the expiry cycle takes priority over the timeout.
          if (btn_pulse[0]) begin
            ans_d   = sw[4:0];
            state_d = S_JUDGE;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            secs_d = secs_q - 4'd1;
            if (secs_q <= 4'd1) begin
              timeout_d = 1'b1;
              state_d   = S_JUDGE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_JUDGE: begin
          ok_d    = correct;
          round_d = round_q + 8'd1;
          if (correct) begin
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
`ifdef STREAK_BONUS_EN
            streak_d = (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
          end else begin
            streak_d = '0;
`endif
          end
          state_d = ((round_q + 8'd1) == 8'(NUM_ROUNDS)) ? S_DONE : S_RESULT;
        end
        S_RESULT: if (btn_pulse[0]) state_d = S_LOAD;
        S_DONE:   if (btn_pulse[0]) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Display image, registered one cycle behind the internal state.
  always_comb begin
    therm = '0;
    for (int i = 0; i < 8; i++) therm[i] = (secs_q > 4'(i));

    led_d        = '0;
    led_d[3:0]   = a_q;
    led_d[7:4]   = b_q;
    led_d[8]     = op_q;
    led_d[12:9]  = (state_q == S_ASK) ? secs_q : 4'd0;
    led_d[13]    = ok_q;
    led_d[14]    = (state_q == S_LOAD) || (state_q == S_ASK) ||
                   (state_q == S_JUDGE) || (state_q == S_RESULT);
    led_d[15]    = (state_q == S_DONE);

    grid_d = '0;
    if (state_q != S_IDLE) begin
      grid_d[7:0]   = {4'd0, a_q};
      grid_d[15:8]  = {4'd0, b_q};
      if ((state_q == S_RESULT) || (state_q == S_DONE)) grid_d[31:24] = {3'd0, expected};
      grid_d[63:56] = therm;
    end
  end

  assign led      = led_q;
  assign grid     = grid_q;
  assign check_ok = check_ok_q;
  assign score    = score_out_q;

endmodule
